// File: rtl/sram_axi_lite_arbiter_if.sv
// Bus bundle for sram_axi_lite_arbiter: the N requester-side SRAM-style ports
// plus the single AXI4-Lite master channel set.
// The modports are named from the requester side:
//   - slave:  the arbiter's view (it serves the requesters and drives AXI).
//   - master: the view of the requesters and the AXI memory model.
interface sram_axi_lite_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Requester side
  logic [NUM_PORTS*ADDR_W-1:0] port_addr;
  logic [NUM_PORTS-1:0]        port_ce;
  logic [NUM_PORTS-1:0]        port_we;
  logic [NUM_PORTS*DATA_W-1:0] port_wdata;
  logic [NUM_PORTS*STRB_W-1:0] port_wmask;
  logic [NUM_PORTS-1:0]        port_flush;
  logic [DATA_W-1:0]           port_rdata;
  logic [NUM_PORTS-1:0]        port_rdata_valid;
  logic [NUM_PORTS-1:0]        port_write_finish;
  logic [1:0]                  port_bresp;

  // AXI4-Lite side
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_prot;
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_prot;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic [STRB_W-1:0] wstrb;
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_breap;

  modport slave (
    input  port_addr, port_ce, port_we, port_wdata, port_wmask, port_flush,
    output port_rdata, port_rdata_valid, port_write_finish, port_bresp,
    output ar_valid, ar_addr, ar_prot, aw_valid, aw_addr, aw_prot,
    output rd_ready, wd_valid, wd_data, wstrb, wr_ready,
    input  ar_ready, aw_ready, rd_valid, rd_data, wd_ready, wr_valid, wr_breap
  );

  modport master (
    output port_addr, port_ce, port_we, port_wdata, port_wmask, port_flush,
    input  port_rdata, port_rdata_valid, port_write_finish, port_bresp,
    input  ar_valid, ar_addr, ar_prot, aw_valid, aw_addr, aw_prot,
    input  rd_ready, wd_valid, wd_data, wstrb, wr_ready,
    output ar_ready, aw_ready, rd_valid, rd_data, wd_ready, wr_valid, wr_breap
  );
endinterface

// File: rtl/sram_axi_lite_arbiter.sv
// N-port SRAM-style requester to single AXI4-Lite memory bridge.
// One transaction outstanding at a time; read returns can be discarded per
// port (flush); write responses are reported with the completion pulse.
// Optional build macro ARB_FIXED_PRIO_EN: when defined, the lowest requesting
// index always wins and the round-robin pointer is removed; otherwise the
// first requester at or after the round-robin pointer is granted.
module sram_axi_lite_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  sram_axi_lite_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]    wmask_q, wmask_d;
  logic                 discard_q, discard_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [NUM_PORTS-1:0] rvld_q, rvld_d;
  logic [NUM_PORTS-1:0] wfin_q, wfin_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]     rr_q, rr_d;
`endif

  // Arbitration and per-port selection results
  logic                 req_any;
  logic [IDX_W-1:0]     req_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_we;
  logic [DATA_W-1:0]    sel_wdata;
  logic [STRB_W-1:0]    sel_wmask;
  logic                 sel_flush;
  logic                 gnt_flush;
  logic [NUM_PORTS-1:0] gnt_oh;
  logic [IDX_W-1:0]     gnt_next;

  // AXI handshake outputs decoded from the state
  logic ar_valid_c, aw_valid_c, wd_valid_c, rd_ready_c, wr_ready_c;

  // Pick the winning requester; round-robin scans from the pointer first and
  // then falls back to the lowest index, which wraps the search.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
`ifndef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req_any && bus.port_ce[i] && (IDX_W'(i) >= rr_q)) begin
        req_any = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req_any && bus.port_ce[i]) begin
        req_any = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
  end

  // Mux the request fields of the winner and decode the current grant.
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    sel_flush = 1'b0;
    gnt_flush = 1'b0;
    gnt_oh    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (IDX_W'(i) == req_idx) begin
        sel_addr  = bus.port_addr[i*ADDR_W +: ADDR_W];
        sel_we    = bus.port_we[i];
        sel_wdata = bus.port_wdata[i*DATA_W +: DATA_W];
        sel_wmask = bus.port_wmask[i*STRB_W +: STRB_W];
        sel_flush = bus.port_flush[i];
      end
      if (IDX_W'(i) == gnt_q) begin
        gnt_flush = bus.port_flush[i];
        gnt_oh[i] = 1'b1;
      end
    end
    gnt_next = (gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
  end

  // Transaction FSM: next state, latched request, completion pulses.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    discard_d  = discard_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rdata_d    = rdata_q;
    bresp_d    = bresp_q;
    rvld_d     = '0;
    wfin_d     = '0;
`ifndef ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    ar_valid_c = 1'b0;
    aw_valid_c = 1'b0;
    wd_valid_c = 1'b0;
    rd_ready_c = 1'b0;
    wr_ready_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          gnt_d     = req_idx;
          addr_d    = sel_addr;
          we_d      = sel_we;
          wdata_d   = sel_wdata;
          wmask_d   = sel_wmask;
          // A flush raised in the grant cycle already counts for a read.
          discard_d = sel_flush & ~sel_we;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sel_we ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        ar_valid_c = 1'b1;
        if (gnt_flush) discard_d = 1'b1;
        if (bus.ar_ready) state_d = S_R;
      end
      S_R: begin
        rd_ready_c = 1'b1;
        if (gnt_flush) discard_d = 1'b1;
        if (bus.rd_valid) begin
          // Data is always captured; only the valid pulse is suppressed.
          rdata_d = bus.rd_data;
          if (!(discard_q || gnt_flush)) rvld_d = gnt_oh;
          state_d = S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = gnt_next;
`endif
        end
      end
      S_AW_W: begin
        aw_valid_c = ~aw_done_q;
        wd_valid_c = ~w_done_q;
        aw_done_d  = aw_done_q | bus.aw_ready;
        w_done_d   = w_done_q | bus.wd_ready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        wr_ready_c = 1'b1;
        if (bus.wr_valid) begin
          // An error response still completes the write.
          bresp_d = bus.wr_breap;
          wfin_d  = gnt_oh;
          state_d = S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = gnt_next;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      discard_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      bresp_q   <= '0;
      rvld_q    <= '0;
      wfin_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      discard_q <= discard_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rvld_q    <= rvld_d;
      wfin_q    <= wfin_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign bus.ar_valid          = ar_valid_c;
  assign bus.ar_addr           = addr_q;
  assign bus.ar_prot           = 3'b000;
  assign bus.aw_valid          = aw_valid_c;
  assign bus.aw_addr           = addr_q;
  assign bus.aw_prot           = 3'b000;
  assign bus.rd_ready          = rd_ready_c;
  assign bus.wd_valid          = wd_valid_c;
  assign bus.wd_data           = wdata_q;
  assign bus.wstrb             = wmask_q;
  assign bus.wr_ready          = wr_ready_c;
  assign bus.port_rdata        = rdata_q;
  assign bus.port_rdata_valid  = rvld_q;
  assign bus.port_write_finish = wfin_q;
  assign bus.port_bresp        = bresp_q;

endmodule
